// File: rtl/d16_sequencer.sv
// Instruction sequencer for the d16 core: owns the PC, fetches words for d16_decode,
// resolves JMP/JMZ locally and hands ALU/move ops to the datapath via ex_stb/ex_ack.
//
// state  | meaning
// IDLE   | parked; waits for run at an instruction boundary
// FETCH  | imem_stb high at pc; latches imem_dat into instr on imem_ack
// DECODE | one cycle; resolves jumps, dispatches ALU ops, traps illegal opcodes
// EXEC   | ex_stb high; retires the instruction on ex_ack
// HALT   | illegal opcode seen; only sys_rst leaves
module d16_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        run,
    output logic [15:0] imem_adr,
    output logic        imem_stb,
    input  logic        imem_ack,
    input  logic [31:0] imem_dat,
    output logic [31:0] instr,
    input  logic [7:0]  op_in,
    input  logic [15:0] a_in,
    input  logic        zero,
    output logic        ex_stb,
    input  logic        ex_ack,
    output logic [15:0] pc,
    output logic [31:0] instret,
    output logic        busy,
    output logic        err
);

    // Opcode values mirror d16.vh so this file stands alone.
    localparam logic [7:0] D16_OP_ADD = 8'h00;
    localparam logic [7:0] D16_OP_SUB = 8'h01;
    localparam logic [7:0] D16_OP_SHL = 8'h02;
    localparam logic [7:0] D16_OP_SHR = 8'h03;
    localparam logic [7:0] D16_OP_COP = 8'h04;
    localparam logic [7:0] D16_OP_AFC = 8'h05;
    localparam logic [7:0] D16_OP_JMP = 8'h06;
    localparam logic [7:0] D16_OP_JMZ = 8'h07;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instret;
    logic        r_err;

    state_t      w_state_nxt;
    logic [15:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_instret_nxt;
    logic        w_err_nxt;
    state_t      w_after_retire;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= 32'h0000_0000;
            r_instret <= 32'h0000_0000;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_instr   <= w_instr_nxt;
            r_instret <= w_instret_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instret_nxt  = r_instret;
        w_err_nxt      = r_err;
        w_after_retire = run ? FETCH : IDLE;
        case (r_state)
            IDLE: begin
                if (run) w_state_nxt = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    w_instr_nxt = imem_dat;
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                case (op_in)
                    D16_OP_ADD, D16_OP_SUB, D16_OP_SHL,
                    D16_OP_SHR, D16_OP_COP, D16_OP_AFC: begin
                        w_state_nxt = EXEC;
                    end
                    D16_OP_JMP: begin
                        w_pc_nxt      = a_in;
                        w_instret_nxt = r_instret + 32'd1;
                        w_state_nxt   = w_after_retire;
                    end
                    D16_OP_JMZ: begin
                        w_pc_nxt      = zero ? a_in : r_pc + 16'd1;
                        w_instret_nxt = r_instret + 32'd1;
                        w_state_nxt   = w_after_retire;
                    end
                    // pc is left on the faulting word for post-mortem inspection
                    default: begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = HALT;
                    end
                endcase
            end
            EXEC: begin
                if (ex_ack) begin
                    w_pc_nxt      = r_pc + 16'd1;
                    w_instret_nxt = r_instret + 32'd1;
                    w_state_nxt   = w_after_retire;
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign imem_stb = (r_state == FETCH);
    assign ex_stb   = (r_state == EXEC);
    assign busy     = (r_state != IDLE) && (r_state != HALT);
    assign imem_adr = r_pc;
    assign pc       = r_pc;
    assign instr    = r_instr;
    assign instret  = r_instret;
    assign err      = r_err;

endmodule

// File: tb/tb_d16_sequencer.sv
// Scoreboarded bench for d16_sequencer: expected fetch addresses are queued per program
// run and popped as the DUT completes fetches; decode and memory are modelled here.
module tb_d16_sequencer;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_AFC = 8'h05;
    localparam logic [7:0] OP_JMP = 8'h06;
    localparam logic [7:0] OP_JMZ = 8'h07;
    localparam logic [7:0] OP_BAD = 8'hFF;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        run;
    logic [15:0] imem_adr;
    logic        imem_stb;
    logic        imem_ack;
    logic [31:0] imem_dat;
    logic [31:0] instr;
    logic [7:0]  op_in;
    logic [15:0] a_in;
    logic        zero;
    logic        ex_stb;
    logic        ex_ack;
    logic [15:0] pc;
    logic [31:0] instret;
    logic        busy;
    logic        err;

    d16_sequencer #(.RESET_PC(16'h0000)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .run     (run),
        .imem_adr(imem_adr),
        .imem_stb(imem_stb),
        .imem_ack(imem_ack),
        .imem_dat(imem_dat),
        .instr   (instr),
        .op_in   (op_in),
        .a_in    (a_in),
        .zero    (zero),
        .ex_stb  (ex_stb),
        .ex_ack  (ex_ack),
        .pc      (pc),
        .instret (instret),
        .busy    (busy),
        .err     (err)
    );

    always #5 sys_clk = ~sys_clk;

    logic [31:0] mem [0:65535];
    assign imem_dat = mem[imem_adr];
    assign op_in    = instr[31:24];
    assign a_in     = instr[15:0];

    int imem_wait = 0;
    int ex_wait   = 0;
    int fcnt      = 0;
    int ecnt      = 0;
    int cyc       = 0;
    assign imem_ack = imem_stb && (fcnt >= imem_wait);
    assign ex_ack   = ex_stb && (ecnt >= ex_wait);

    always @(posedge sys_clk) begin
        fcnt <= (imem_stb && !imem_ack) ? fcnt + 1 : 0;
        ecnt <= (ex_stb && !ex_ack) ? ecnt + 1 : 0;
        cyc  <= cyc + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    logic [31:0] exp_adr_q [$];
    int          fetch_cyc_q [$];
    int          fetches_seen = 0;
    int          busy_cyc = 0;
    int          ex_cyc = 0;
    int          ex_pulses = 0;
    int          strobe_cyc = 0;
    int          viol = 0;

    logic        prev_fw = 1'b0;
    logic        prev_ex = 1'b0;
    logic        prev_exw = 1'b0;
    logic [15:0] prev_adr = 16'h0;
    logic [15:0] prev_pc = 16'h0;
    logic [31:0] prev_instr = 32'h0;

    always @(negedge sys_clk) begin
        logic [31:0] e;
        if (!sys_rst) begin
            if (imem_stb && imem_ack) begin
                fetches_seen++;
                fetch_cyc_q.push_back(cyc);
                e = (exp_adr_q.size() > 0) ? exp_adr_q.pop_front() : 32'hDEAD_BEEF;
                chk("fetch_adr", {16'h0, imem_adr}, e);
            end
            if (busy) busy_cyc++;
            if (ex_stb) ex_cyc++;
            if (ex_stb && ex_ack) ex_pulses++;
            if (imem_stb || ex_stb) strobe_cyc++;
            if (prev_fw && imem_stb && (imem_adr != prev_adr || instr != prev_instr)) viol++;
            if (prev_ex && ex_stb && instr != prev_instr) viol++;
            if (prev_exw && pc != prev_pc) viol++;
        end
        prev_fw    = !sys_rst && imem_stb && !imem_ack;
        prev_ex    = !sys_rst && ex_stb;
        prev_exw   = !sys_rst && ex_stb && !ex_ack;
        prev_adr   = imem_adr;
        prev_pc    = pc;
        prev_instr = instr;
    end

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [15:0] a);
        return {op, 8'h00, a};
    endfunction

    task automatic run_prog(input int nf, input int budget);
        int t;
        t = 0;
        fetches_seen = 0;
        busy_cyc = 0;
        ex_cyc = 0;
        ex_pulses = 0;
        fetch_cyc_q.delete();
        run = 1'b1;
        while (fetches_seen < nf && t < budget) begin
            @(negedge sys_clk); #1; t++;
        end
        run = 1'b0;
        while (busy && t < budget) begin
            @(negedge sys_clk); #1; t++;
        end
        chk("run_budget", (t < budget) ? 32'd1 : 32'd0, 32'd1);
        chk("sb_drained", exp_adr_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
    endtask

    function automatic int gap(input int i);
        if (fetch_cyc_q.size() > i + 1) return fetch_cyc_q[i+1] - fetch_cyc_q[i];
        return -1;
    endfunction

    initial begin
        int t;
        sys_rst = 1'b1;
        run     = 1'b0;
        zero    = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = ins(OP_BAD, 16'h0);
        mem[16'h0000] = ins(OP_ADD, 16'h0);
        mem[16'h0001] = ins(OP_SUB, 16'h0);
        mem[16'h0002] = ins(OP_JMP, 16'h0005);
        mem[16'h0005] = ins(OP_JMP, 16'h0040);
        mem[16'h0040] = ins(OP_JMP, 16'h0007);
        mem[16'h0007] = ins(OP_JMZ, 16'h0010);
        mem[16'h0010] = ins(OP_JMP, 16'h0007);
        mem[16'h0008] = ins(OP_AFC, 16'h1234);
        mem[16'h0009] = ins(OP_JMP, 16'hFFFF);
        mem[16'hFFFF] = ins(OP_ADD, 16'h0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_imem_stb", {31'h0, imem_stb}, 32'h0);
        chk("rst_ex_stb", {31'h0, ex_stb}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);

        // two ALU ops, zero wait states
        exp_adr_q.push_back(32'h0000);
        exp_adr_q.push_back(32'h0001);
        run_prog(2, 50);
        chk("alu_gap", gap(0), 32'd3);
        chk("alu_busy_cyc", busy_cyc, 32'd6);
        chk("alu_ex_cyc", ex_cyc, 32'd2);
        chk("alu_ex_pulses", ex_pulses, 32'd2);
        chk("alu_instret", instret, 32'd2);
        chk("alu_pc", {16'h0, pc}, 32'h0002);
        chk("alu_busy_end", {31'h0, busy}, 32'h0);

        // jump chain 2 -> 5 -> 0x40 -> 7
        exp_adr_q.push_back(32'h0002);
        exp_adr_q.push_back(32'h0005);
        exp_adr_q.push_back(32'h0040);
        run_prog(3, 50);
        chk("jmp_gap0", gap(0), 32'd2);
        chk("jmp_gap1", gap(1), 32'd2);
        chk("jmp_ex_cyc", ex_cyc, 32'd0);
        chk("jmp_busy_cyc", busy_cyc, 32'd6);
        chk("jmp_instret", instret, 32'd5);
        chk("jmp_pc", {16'h0, pc}, 32'h0007);

        // JMZ taken
        zero = 1'b1;
        exp_adr_q.push_back(32'h0007);
        exp_adr_q.push_back(32'h0010);
        run_prog(2, 50);
        chk("jmz_t_instret", instret, 32'd7);
        chk("jmz_t_pc", {16'h0, pc}, 32'h0007);

        // JMZ not taken
        zero = 1'b0;
        exp_adr_q.push_back(32'h0007);
        run_prog(1, 50);
        chk("jmz_nt_pc", {16'h0, pc}, 32'h0008);
        chk("jmz_nt_instret", instret, 32'd8);
        chk("jmz_nt_busy_cyc", busy_cyc, 32'd2);

        // latency stretch on AFC
        imem_wait = 3;
        ex_wait   = 2;
        viol      = 0;
        exp_adr_q.push_back(32'h0008);
        run_prog(1, 100);
        chk("lat_busy_cyc", busy_cyc, 32'd8);
        chk("lat_ex_cyc", ex_cyc, 32'd3);
        chk("lat_ex_pulses", ex_pulses, 32'd1);
        chk("lat_pc", {16'h0, pc}, 32'h0009);
        chk("lat_instret", instret, 32'd9);
        chk("lat_instr", instr, ins(OP_AFC, 16'h1234));
        chk("lat_stability", viol, 32'd0);
        imem_wait = 0;
        ex_wait   = 0;

        // pc wrap 0xFFFF -> 0x0000
        exp_adr_q.push_back(32'h0009);
        exp_adr_q.push_back(32'hFFFF);
        exp_adr_q.push_back(32'h0000);
        run_prog(3, 50);
        chk("wrap_gap0", gap(0), 32'd2);
        chk("wrap_gap1", gap(1), 32'd3);
        chk("wrap_pc", {16'h0, pc}, 32'h0001);
        chk("wrap_instret", instret, 32'd12);

        // illegal opcode at 0x0003
        mem[16'h0000] = ins(OP_JMP, 16'h0003);
        mem[16'h0003] = ins(OP_BAD, 16'h0);
        do_reset();
        exp_adr_q.push_back(32'h0000);
        exp_adr_q.push_back(32'h0003);
        run_prog(2, 50);
        chk("ill_err", {31'h0, err}, 32'h1);
        chk("ill_pc", {16'h0, pc}, 32'h0003);
        chk("ill_instret", instret, 32'd1);
        chk("ill_busy", {31'h0, busy}, 32'h0);
        run = 1'b1;
        strobe_cyc = 0;
        repeat (6) @(negedge sys_clk);
        #1;
        chk("halt_no_strobes", strobe_cyc, 32'd0);
        chk("halt_err_sticky", {31'h0, err}, 32'h1);
        run = 1'b0;
        do_reset();
        chk("halt_rst_err", {31'h0, err}, 32'h0);
        chk("halt_rst_pc", {16'h0, pc}, 32'h0);
        chk("halt_rst_instret", instret, 32'd0);
        chk("halt_rst_busy", {31'h0, busy}, 32'h0);

        // reset mid-FETCH with imem_ack high
        mem[16'h0000] = ins(OP_ADD, 16'h0);
        run = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("mf_in_fetch", {30'h0, imem_stb, imem_ack}, 32'h3);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("mf_instr", instr, 32'h0);
        chk("mf_busy", {31'h0, busy}, 32'h0);
        chk("mf_imem_stb", {31'h0, imem_stb}, 32'h0);
        run = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        chk("mf_idle_pc", {16'h0, pc}, 32'h0);

        // reset mid-EXEC
        ex_wait = 5;
        exp_adr_q.push_back(32'h0000);
        run = 1'b1;
        t = 0;
        while (!ex_stb && t < 20) begin
            @(negedge sys_clk); #1; t++;
        end
        chk("me_reached_exec", {31'h0, ex_stb}, 32'h1);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("me_ex_stb", {31'h0, ex_stb}, 32'h0);
        chk("me_pc", {16'h0, pc}, 32'h0);
        chk("me_instret", instret, 32'd0);
        chk("me_instr", instr, 32'h0);
        chk("me_busy", {31'h0, busy}, 32'h0);
        run = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        ex_wait = 0;
        repeat (3) @(negedge sys_clk);
        #1;
        chk("me_parked", {30'h0, busy, ex_stb}, 32'h0);
        chk("sb_final", exp_adr_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
